// File: rtl/arith_shift_pkg.sv
// -----------------------------------------------------------------------------
// arith_shift_pkg
// Shared definitions for the arithmetic shift library:
//   - state_t   : FSM state encoding for the sequential shifters (ST_IDLE, ST_SHIFT)
//   - sat_max() : most positive two's-complement value of a given width
//   - sat_min() : most negative two's-complement value of a given width
// The saturation helpers return a SAT_MAX_W-bit vector; callers keep the low
// <width> bits. Widths up to SAT_MAX_W are supported.
// -----------------------------------------------------------------------------
package arith_shift_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int unsigned SAT_MAX_W = 64;

    // 0111...1 in the low <width> bits.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width);
        logic [SAT_MAX_W-1:0] ones;
        ones = {SAT_MAX_W{1'b1}};
        return ones >> (SAT_MAX_W - width + 32'd1);
    endfunction

    // 1000...0 in the low <width> bits.
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width);
        logic [SAT_MAX_W-1:0] one;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        return one << (width - 32'd1);
    endfunction

endpackage

// File: rtl/arith_shift_step_left.sv
// -----------------------------------------------------------------------------
// arith_shift_step_left
// Combinational single-bit arithmetic left-shift step with overflow detection
// and optional saturation.
// Ports:
//   i_y        : current working value (signed, WIDTH bits)
//   i_sgn      : sign of the original operand (selects the clamp direction)
//   o_next_y   : value after this step
//   o_step_ovf : this step overflows (the two top bits of i_y differ)
// When SATURATE is set and the step overflows, the result is clamped to the
// signed max/min selected by i_sgn. Once clamped, the working value is already
// the clamp value and every later step overflows again into the same value,
// so the result holds without any extra "saturated" state.
// -----------------------------------------------------------------------------
module arith_shift_step_left
    import arith_shift_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic signed [WIDTH-1:0] i_y,
    input  logic                    i_sgn,
    output logic signed [WIDTH-1:0] o_next_y,
    output logic                    o_step_ovf
);

    localparam logic [SAT_MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [SAT_MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_MAX_V    = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_MIN_V    = SAT_MIN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] w_shifted;

    // One shift step: detect sign loss, then wrap or clamp.
    always_comb begin
        w_shifted  = {i_y[WIDTH-2:0], 1'b0};
        o_step_ovf = i_y[WIDTH-1] ^ i_y[WIDTH-2];
        if (SATURATE && o_step_ovf) begin
            o_next_y = i_sgn ? SAT_MIN_V : SAT_MAX_V;
        end else begin
            o_next_y = w_shifted;
        end
    end

endmodule

// File: rtl/arith_shift_left_seq.sv
// -----------------------------------------------------------------------------
// arith_shift_left_seq
// Sequential signed arithmetic left shifter (multiply by 2^shamt), one bit per
// clock, with sticky two's-complement overflow and optional saturation.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : synchronous active-high reset (abandons any operation in flight)
//   i_start : request, sampled only while idle
//   i_a     : signed operand, captured on accept
//   i_shamt : shift count, captured on accept (values >= WIDTH are legal)
//   o_y     : working/result register; final while o_done is high
//   o_busy  : high from the accept edge until completion
//   o_done  : one-cycle completion pulse
//   o_ovf   : sticky overflow of the current/last operation
// Latency from accept to done is shamt+1 cycles; a start in the done cycle is
// accepted.
// -----------------------------------------------------------------------------
module arith_shift_left_seq
    import arith_shift_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SHW      = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic        [SHW-1:0]   i_shamt,
    output logic signed [WIDTH-1:0] o_y,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_ovf
);

    state_t                  r_state;
    logic        [SHW-1:0]   r_cnt;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_sgn;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ovf;

    logic signed [WIDTH-1:0] w_next_y;
    logic                    w_step_ovf;

    arith_shift_step_left #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_step (
        .i_y        (r_y),
        .i_sgn      (r_sgn),
        .o_next_y   (w_next_y),
        .o_step_ovf (w_step_ovf)
    );

    // Control FSM, step counter and all output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {SHW{1'b0}};
            r_y     <= {WIDTH{1'b0}};
            r_sgn   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_y     <= i_a;
                        r_cnt   <= i_shamt;
                        r_sgn   <= i_a[WIDTH-1];
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end else begin
                        // done is a single-cycle pulse; y and ovf hold.
                        r_done  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != {SHW{1'b0}}) begin
                        r_cnt <= r_cnt - {{(SHW-1){1'b0}}, 1'b1};
                        r_y   <= w_next_y;
                        r_ovf <= r_ovf | w_step_ovf;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_y    = r_y;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_ovf  = r_ovf;

endmodule

// File: doc/arith_shift_left_seq.md
# arith_shift_left_seq

Sequential signed arithmetic left shifter, the multiply-by-2^n counterpart of the combinational arithmetic right shifter in the arithmetic shift library. It accepts a signed operand and a shift amount on a start strobe, then shifts one bit per clock. It tracks two's-complement overflow and optionally saturates. Completion is signalled with a one-cycle done pulse, for use by sequential datapath and scaling controllers.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- SHW, 3, shift-amount width in bits
- SATURATE, 0, 1 = clamp the result to the signed max/min on overflow; 0 = wrap
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  signed WIDTH  operand, captured on an accepted start
- shamt  input  SHW  shift count, captured on an accepted start
- y  output  signed WIDTH  working/result register
- busy  output  1  high from the cycle after acceptance until completion
- done  output  1  one-cycle pulse; y is final while done is high
- ovf  output  1  sticky overflow for the current operation

## Operation
- States: IDLE, SHIFT. IDLE→SHIFT on start; SHIFT→IDLE when cnt==0.
- Reset: state=IDLE, y=0, cnt=0, busy=0, done=0, ovf=0. Reset has priority over everything, including an operation in progress, which is abandoned with no done pulse.
- Accept (IDLE && start): y←a, cnt←shamt, sgn←a[WIDTH-1], ovf←0, busy←1, done←0.
- SHIFT with cnt≠0: cnt←cnt−1; one step is applied.
  - Overflow on a step: y[WIDTH-1]≠y[WIDTH-2] before the step. Any overflow step sets ovf.
  - SATURATE=0: y←{y[WIDTH-2:0],1'b0} on every step.
  - SATURATE=1, before the first overflow: same as SATURATE=0.
  - SATURATE=1, on the overflowing step: y←sgn ? {1,0…0} : {0,1…1}.
  - SATURATE=1, after saturation: y holds for the remaining steps.
- SHIFT with cnt==0: done←1, busy←0, state←IDLE. y holds.
- done clears on the next edge unless that edge accepts a new start, which also clears it.
- start while busy is ignored. a and shamt are don't-care outside accept.
- shamt ≥ WIDTH is legal. Any nonzero operand then overflows. An operand of 0 gives y=0 with ovf=0.
- A zero operand never overflows.

## Timing
- Start accepted at edge k:
  - busy=1 from edge k.
  - Shifts occur at edges k+1 … k+shamt.
  - done=1 and busy=0 from edge k+shamt+1, for exactly one cycle.
- Latency from start to done is shamt+1 cycles. shamt=0 gives done at k+1 with y=a.
- ovf is valid when done is high. It holds until the next accept or reset.
- Back-to-back: a start presented in the done cycle is accepted. The next done pulse then follows at that edge+shamt+1.

## Structure
- Shared package (arith_shift_pkg): state encoding constants (ST_IDLE, ST_SHIFT).
- Shared package also holds the saturation-value functions sat_max(WIDTH) and sat_min(WIDTH).
- One sub-module: arith_shift_step_left, combinational. It takes y, sgn and SATURATE and returns next_y and step_ovf.
- Top level contains the FSM, counter and registers only.

## Test plan
- Reset, then a=0011 (3), shamt=1, start at edge k → done at k+2 with y=0110 (6), ovf=0, busy low in the done cycle.
- a=1110 (−2), shamt=2 → y=1000 (−8), ovf=0, done at k+3.
- SATURATE=0: a=0111 (+7), shamt=1 → y=1110, ovf=1. SATURATE=1: same stimulus → y=0111 (+7), ovf=1.
- SATURATE=1: a=1000 (−8), shamt=3 → y=1000, ovf=1, done at k+4. a=0000, shamt=7 → y=0, ovf=0.
- a=0101, shamt=0 → done at k+1 with y=0101. A start pulsed while busy during a shamt=3 run has no effect. A new start in the done cycle is accepted.
- rst asserted at k+2 of a shamt=3 run → next edge y=0, busy=0, done=0, ovf=0, with no done pulse afterwards.
